// File: rtl/conv_pkg.sv
// Shared constants and helpers for the streaming binary convolution.
package conv_pkg;

    localparam int IMG_W_DEF = 16;
    localparam int IMG_H_DEF = 16;
    localparam int K_DEF     = 3;

    function automatic int acc_width(input int k);
        return $clog2(k * k + 1);
    endfunction

    localparam int ACC_W_DEF = acc_width(K_DEF);

    typedef struct packed {
        logic                 last;
        logic [ACC_W_DEF-1:0] data;
    } out_beat_t;

endpackage

// File: rtl/conv_stream_lb_popcount.sv
// Combinational popcount of window bits selected by a binary kernel mask.
module masked_popcount #(
    parameter int N     = 9,
    parameter int ACC_W = 4
) (
    input  logic [N-1:0]     window,
    input  logic [N-1:0]     mask,
    output logic [ACC_W-1:0] sum
);

    logic [N-1:0] w_hits;

    assign w_hits = window & mask;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++)
            sum = sum + ACC_W'(w_hits[i]);
    end

endmodule

// File: rtl/conv_stream_lb.sv
// Streaming KxK binary convolution over a raster pixel stream, using K-1
// line buffers and a single registered valid/ready output stage.
module conv_stream_lb
    import conv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int K     = K_DEF,
    parameter int ACC_W = acc_width(K)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [K*K-1:0]   kernel_mask,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             pix_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    if (ACC_W < acc_width(K)) begin : g_acc_w_chk
        $error("conv_stream_lb: ACC_W too narrow for K*K popcount");
    end
    if (K < 2 || IMG_W < K || IMG_H < K) begin : g_geom_chk
        $error("conv_stream_lb: image must be at least KxK with K >= 2");
    end

    logic [1:0]              r_rst_sync;
    logic                    w_rst_n;
    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic [K-2:0][IMG_W-1:0] r_lb;
    logic [K-1:0][K-1:0]     r_win;
    logic [K-1:0][K-1:0]     w_win_nxt;
    logic [K-1:0]            w_newcol;
    logic [K*K-1:0]          r_mask;
    logic [ACC_W-1:0]        w_sum;
    logic                    w_acc;
    logic                    w_fire;
    logic                    w_col_end;
    logic                    w_row_end;
    logic                    w_first;

    // Reset asserts asynchronously but releases two clocks later, in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n   = r_rst_sync[1];
    assign pix_ready = w_rst_n && (!out_valid || out_ready);
    assign w_acc     = pix_valid && pix_ready;
    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_row_end = (r_row == RW'(IMG_H - 1));
    assign w_first   = (r_col == '0) && (r_row == '0);
    assign w_fire    = w_acc && (r_row >= RW'(K - 1)) && (r_col >= CW'(K - 1));

    // New rightmost column: row K-1 is the live pixel, older rows come from buffer tails.
    always_comb begin
        w_newcol        = '0;
        w_newcol[K-1]   = pix_data;
        for (int m = 0; m < K - 1; m++)
            w_newcol[K-2-m] = r_lb[m][IMG_W-1];
    end

    always_comb begin
        w_win_nxt = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++)
                w_win_nxt[r][c] = r_win[r][c+1];
            w_win_nxt[r][K-1] = w_newcol[r];
        end
    end

    // Packed [row][col] flattens to bit r*K+c, matching the kernel_mask layout.
    masked_popcount #(
        .N     (K * K),
        .ACC_W (ACC_W)
    ) u_popcount (
        .window (w_win_nxt),
        .mask   (r_mask),
        .sum    (w_sum)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_lb      <= '0;
            r_win     <= '0;
            r_mask    <= '1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_col <= w_col_end ? '0 : r_col + 1'b1;
                if (w_col_end)
                    r_row <= w_row_end ? '0 : r_row + 1'b1;
                r_lb[0] <= {r_lb[0][IMG_W-2:0], pix_data};
                for (int i = 1; i < K - 1; i++)
                    r_lb[i] <= {r_lb[i][IMG_W-2:0], r_lb[i-1][IMG_W-1]};
                r_win <= w_win_nxt;
                if (w_first)
                    r_mask <= kernel_mask;
            end
            if (w_fire) begin
                out_valid <= 1'b1;
                out_data  <= w_sum;
                out_last  <= w_col_end && w_row_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
